// File: rtl/memory_port_controller_if.sv
// Host request/response, clear control and single-port memory signals for memory_port_controller.
// The slave view belongs to the controller; the master view belongs to the host plus the memory.
interface memory_port_controller_if #(
    parameter int DATAWIDTH    = 8,
    parameter int ADDRESSWIDTH = 10
);
    logic                    reqValid;
    logic                    reqReady;
    logic                    reqWrite;
    logic [ADDRESSWIDTH-1:0] reqAddress;
    logic [DATAWIDTH-1:0]    reqData;
    logic                    rspValid;
    logic                    rspReady;
    logic [DATAWIDTH-1:0]    rspData;
    logic                    clearReq;
    logic                    clearBusy;
    logic                    memWriteEn;
    logic [DATAWIDTH-1:0]    memDataIn;
    logic [ADDRESSWIDTH-1:0] memAddress;
    logic [DATAWIDTH-1:0]    memDataOut;

    modport slave (
        input  reqValid, reqWrite, reqAddress, reqData, rspReady, clearReq, memDataOut,
        output reqReady, rspValid, rspData, clearBusy, memWriteEn, memDataIn, memAddress
    );

    modport master (
        output reqValid, reqWrite, reqAddress, reqData, rspReady, clearReq, memDataOut,
        input  reqReady, rspValid, rspData, clearBusy, memWriteEn, memDataIn, memAddress
    );
endinterface

// File: rtl/memory_port_controller.sv
// Single-port memory controller: zero-fills memory after reset or on request, then serves
// host reads/writes with one read per cycle and a back-pressured, stable read response.
module memory_port_controller #(
    parameter int DATAWIDTH    = 8,
    parameter int DATADEPTH    = 1024,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
    input  logic                    clk,
    input  logic                    resetn,
    memory_port_controller_if.slave ctrl
);
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CLEAR = 2'd1,
        IDLE  = 2'd2
    } state_t;

    localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(DATADEPTH - 1);

    state_t                  state, next_state;
    logic [ADDRESSWIDTH-1:0] counter, next_counter;
    logic [ADDRESSWIDTH-1:0] addr_reg, next_addr;
    logic                    rsp_valid, next_rsp_valid;
    logic                    accept;
    logic [DATAWIDTH-1:0]    write_data;

    assign write_data    = ctrl.reqData;
    assign ctrl.rspValid = rsp_valid;
    assign ctrl.rspData  = ctrl.memDataOut;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= INIT;
            counter   <= '0;
            addr_reg  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= next_state;
            counter   <= next_counter;
            addr_reg  <= next_addr;
            rsp_valid <= next_rsp_valid;
        end
    end

    always_comb begin
        next_state      = state;
        next_counter    = counter;
        next_addr       = addr_reg;
        next_rsp_valid  = rsp_valid;
        accept          = 1'b0;
        ctrl.reqReady   = 1'b0;
        ctrl.clearBusy  = 1'b0;
        ctrl.memWriteEn = 1'b0;
        ctrl.memDataIn  = '0;
        ctrl.memAddress = addr_reg;

        unique case (state)
            INIT: begin
                ctrl.clearBusy  = 1'b1;
                ctrl.memAddress = '0;
                next_counter    = '0;
                next_state      = CLEAR;
            end

            CLEAR: begin
                ctrl.clearBusy  = 1'b1;
                ctrl.memWriteEn = 1'b1;
                ctrl.memAddress = counter;
                if (counter == LAST_ADDR) begin
                    next_counter = '0;
                    next_state   = IDLE;
                end else begin
                    next_counter = counter + 1'b1;
                end
            end

            IDLE: begin
                // A clear only starts once no response is outstanding, and it wins over any request.
                if (ctrl.clearReq && !rsp_valid) begin
                    next_counter = '0;
                    next_state   = CLEAR;
                end else begin
                    ctrl.reqReady = !rsp_valid || ctrl.rspReady;
                    accept        = ctrl.reqValid && ctrl.reqReady;
                    if (accept) begin
                        ctrl.memAddress = ctrl.reqAddress;
                        next_addr       = ctrl.reqAddress;
                        if (ctrl.reqWrite) begin
                            ctrl.memWriteEn = 1'b1;
                            ctrl.memDataIn  = write_data;
                        end
                    end
                    if (accept && !ctrl.reqWrite) begin
                        next_rsp_valid = 1'b1;
                    end else if (rsp_valid && ctrl.rspReady) begin
                        next_rsp_valid = 1'b0;
                    end
                end
            end

            default: begin
                next_state = INIT;
            end
        endcase
    end
endmodule

// File: tb/tb_memory_port_controller.sv
// Self-checking bench for memory_port_controller (DATAWIDTH=8, DATADEPTH=16) with a
// behavioural one-cycle-latency memory, a reference memory image and a read-response scoreboard.
module tb_memory_port_controller;
    logic clk;
    logic resetn;

    memory_port_controller_if #(.DATAWIDTH(8), .ADDRESSWIDTH(4)) bus();

    memory_port_controller #(
        .DATAWIDTH (8),
        .DATADEPTH (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .ctrl   (bus)
    );

    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    logic [7:0] exp_q [$];
    int unsigned n_cmp;
    int unsigned n_bad;

    typedef struct {
        logic       v;
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
        logic       rr;
        logic       e_rdy;
        logic       e_we;
        logic       e_rv;
    } vec_t;

    vec_t vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read, old data returned on a same-address write.
    always @(posedge clk) begin
        if (bus.memWriteEn) mem[bus.memAddress] <= bus.memDataIn;
        bus.memDataOut <= mem[bus.memAddress];
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [3:0] a, input logic [7:0] d,
                         input logic rr, input logic cr);
        bus.reqValid   = v;
        bus.reqWrite   = w;
        bus.reqAddress = a;
        bus.reqData    = d;
        bus.rspReady   = rr;
        bus.clearReq   = cr;
    endtask

    // Observe the handshakes of the current cycle once inputs have settled.
    task automatic settle();
        #1;
        if (bus.rspValid && bus.rspReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 32'(bus.rspData), 32'hFFFF_FFFF);
            end else begin
                chk("rsp_data", 32'(bus.rspData), 32'(exp_q.pop_front()));
            end
        end
        if (bus.reqValid && bus.reqReady) begin
            if (bus.reqWrite) ref_mem[bus.reqAddress] = bus.reqData;
            else exp_q.push_back(ref_mem[bus.reqAddress]);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic check_init(input string tag);
        chk({tag, "_init_busy"}, 32'(bus.clearBusy), 1);
        chk({tag, "_init_we"}, 32'(bus.memWriteEn), 0);
        chk({tag, "_init_addr"}, 32'(bus.memAddress), 0);
        chk({tag, "_init_din"}, 32'(bus.memDataIn), 0);
        chk({tag, "_init_rdy"}, 32'(bus.reqReady), 0);
        chk({tag, "_init_rv"}, 32'(bus.rspValid), 0);
    endtask

    task automatic clear_run(input string tag);
        for (int i = 0; i < 16; i++) begin
            settle();
            chk($sformatf("%s_clr_we_%0d", tag, i), 32'(bus.memWriteEn), 1);
            chk($sformatf("%s_clr_addr_%0d", tag, i), 32'(bus.memAddress), 32'(i));
            chk($sformatf("%s_clr_din_%0d", tag, i), 32'(bus.memDataIn), 0);
            chk($sformatf("%s_clr_busy_%0d", tag, i), 32'(bus.clearBusy), 1);
            chk($sformatf("%s_clr_rdy_%0d", tag, i), 32'(bus.reqReady), 0);
            next();
        end
        settle();
        chk({tag, "_done_busy"}, 32'(bus.clearBusy), 0);
        chk({tag, "_done_rdy"}, 32'(bus.reqReady), 1);
        next();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;

        //           v     w     a     d      rr    rdy   we    rv
        vecs[0] = '{1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'd2, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 4'd3, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset, one INIT cycle, sixteen zero-fill cycles.
        resetn = 1'b0;
        drive(0, 0, 4'd0, 8'h00, 0, 0);
        next();
        #1;
        check_init("rst");
        next();
        resetn = 1'b1;
        settle();
        check_init("rel");
        next();
        clear_run("boot");

        // Back-to-back writes then reads with continuous response.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rr, 0);
            settle();
            chk($sformatf("vec%0d_rdy", i), 32'(bus.reqReady), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_we", i), 32'(bus.memWriteEn), 32'(vecs[i].e_we));
            chk($sformatf("vec%0d_rv", i), 32'(bus.rspValid), 32'(vecs[i].e_rv));
            next();
        end

        // Write then read the same address on the next cycle.
        drive(1, 1, 4'd3, 8'hA5, 1, 0);
        settle();
        chk("wr_we", 32'(bus.memWriteEn), 1);
        chk("wr_addr", 32'(bus.memAddress), 3);
        chk("wr_din", 32'(bus.memDataIn), 32'hA5);
        next();
        drive(1, 0, 4'd3, 8'h00, 1, 0);
        settle();
        chk("rd_accept_rv", 32'(bus.rspValid), 0);
        chk("rd_accept_we", 32'(bus.memWriteEn), 0);
        next();
        drive(0, 0, 4'd0, 8'h00, 1, 0);
        settle();
        chk("rd_lat_rv", 32'(bus.rspValid), 1);
        next();
        settle();
        chk("rd_after_rv", 32'(bus.rspValid), 0);
        next();

        // Stalled response: reqReady drops and the data holds.
        drive(1, 1, 4'd5, 8'h5C, 1, 0); settle(); next();
        drive(1, 1, 4'd6, 8'h66, 1, 0); settle(); next();
        drive(1, 0, 4'd5, 8'h00, 0, 0);
        settle();
        chk("stall_accept_rdy", 32'(bus.reqReady), 1);
        next();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 4'd6, 8'h00, 0, 0);
            settle();
            chk($sformatf("stall%0d_rdy", k), 32'(bus.reqReady), 0);
            chk($sformatf("stall%0d_rv", k), 32'(bus.rspValid), 1);
            chk($sformatf("stall%0d_data", k), 32'(bus.rspData), 32'h5C);
            chk($sformatf("stall%0d_we", k), 32'(bus.memWriteEn), 0);
            chk($sformatf("stall%0d_addr", k), 32'(bus.memAddress), 5);
            next();
        end
        drive(1, 0, 4'd6, 8'h00, 1, 0);
        settle();
        chk("stall_release_rdy", 32'(bus.reqReady), 1);
        next();
        drive(0, 0, 4'd0, 8'h00, 1, 0); settle(); next();
        settle(); next();

        // clearReq is ignored while a response is outstanding.
        drive(1, 0, 4'd1, 8'h00, 0, 0); settle(); next();
        drive(0, 0, 4'd0, 8'h00, 0, 1);
        settle();
        chk("clr_blocked_busy0", 32'(bus.clearBusy), 0);
        next();
        settle();
        chk("clr_blocked_busy1", 32'(bus.clearBusy), 0);
        chk("clr_blocked_rv", 32'(bus.rspValid), 1);
        next();
        drive(0, 0, 4'd0, 8'h00, 1, 0); settle(); next();

        // clearReq in IDLE wins over a simultaneous request.
        drive(1, 1, 4'd9, 8'hEE, 1, 1);
        settle();
        chk("clr_prio_rdy", 32'(bus.reqReady), 0);
        chk("clr_prio_we", 32'(bus.memWriteEn), 0);
        chk("clr_prio_busy", 32'(bus.clearBusy), 0);
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        next();
        drive(0, 0, 4'd0, 8'h00, 1, 0);
        clear_run("req");
        drive(1, 0, 4'd3, 8'h00, 1, 0); settle(); next();
        drive(1, 0, 4'd5, 8'h00, 1, 0); settle(); next();
        drive(0, 0, 4'd0, 8'h00, 1, 0); settle(); next();
        settle(); next();

        // Reset in the middle of a zero-fill restarts it from address 0.
        drive(0, 0, 4'd0, 8'h00, 0, 0);
        resetn = 1'b0;
        next();
        resetn = 1'b1;
        settle();
        check_init("mid_rel0");
        next();
        for (int i = 0; i < 7; i++) begin
            settle();
            next();
        end
        settle();
        chk("mid_counter7_addr", 32'(bus.memAddress), 7);
        chk("mid_counter7_we", 32'(bus.memWriteEn), 1);
        #2;
        resetn = 1'b0;
        #1;
        check_init("mid_async");
        next();
        resetn = 1'b1;
        settle();
        check_init("mid_rel1");
        next();
        clear_run("restart");

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
